game_control: RTL and testbench

- Per-player round controller that sits directly downstream of the ready/number generator.
- Consumes the OK pulse and the round number NUM, runs the answer window and judges the player's factor entry.
- Races the opponent's controller, keeps both scores and publishes STATE.
- The ready stage reads STATE to clear its ready latches on result states: DRAW, GOOD, OUCH, WIN, LOSE.

---
 rtl/game_control.sv | 209 ++++++++++++++++++++
 tb/tb_game_control.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_control.sv
// game_control: per-player round controller for the factor race.
// Takes the round strobe (OK/NUM) from the ready stage, runs the answer
// window, judges the player's claimed factor, races the opponent controller
// through HIT/OPP_HIT and keeps both scores. STATE is read back by the ready
// stage to clear its latches on result states.
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   START             begins a match from IDLE, WIN or LOSE
//   OK, NUM[3:0]      round-start strobe and round number (valid while OK)
//   ANS_VALID, ANS    player's submitted factor (one-cycle strobe)
//   OPP_HIT           opponent answered correctly this round
//   STATE[3:0]        current state encoding
//   TARGET[3:0]       latched round number
//   TIME_LEFT[3:0]    seconds left in the answer window
//   SCORE, OPP_SCORE  own and opponent points
//   HIT               one-cycle strobe on a correct own answer
module game_control #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned TIME_LIMIT = 9,
  parameter int unsigned DISP_SEC   = 2,
  parameter int unsigned WIN_SCORE  = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       OK,
  input  logic [3:0] NUM,
  input  logic       ANS_VALID,
  input  logic [3:0] ANS,
  input  logic       OPP_HIT,
  output logic [3:0] STATE,
  output logic [3:0] TARGET,
  output logic [3:0] TIME_LEFT,
  output logic [3:0] SCORE,
  output logic [3:0] OPP_SCORE,
  output logic       HIT
);

  localparam int unsigned CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int unsigned VAL_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0000,
    ST_WAIT   = 4'b0001,
    ST_ANSWER = 4'b0010,
    ST_LOCK   = 4'b0011,
    ST_DRAW   = 4'b0110,
    ST_GOOD   = 4'b1000,
    ST_OUCH   = 4'b1001,
    ST_WIN    = 4'b1010,
    ST_LOSE   = 4'b1011
  } state_t;

  state_t             state_q, state_d;
  logic [VAL_W-1:0]   target_q, target_d;
  logic [VAL_W-1:0]   time_q, time_d;
  logic [VAL_W-1:0]   score_q, score_d;
  logic [VAL_W-1:0]   opp_q, opp_d;
  logic               hit_q, hit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VAL_W-1:0]   disp_q, disp_d;

  logic               tick;
  logic               answer_ok;
  logic               disp_done;
  logic               expiring;
  logic [VAL_W-1:0]   divisor;
  logic [VAL_W-1:0]   score_inc;
  logic [VAL_W-1:0]   opp_inc;

  // One-second tick from the free-running divider
  assign tick = (cnt_q == CNT_W'(CLK_FREQ - 1));

  // Last tick of the display hold
  assign disp_done = tick && (disp_q == VAL_W'(DISP_SEC - 1));

  // Tick that ends the answer window
  assign expiring = tick && (time_q <= VAL_W'(1));

  // Saturating score increments
  assign score_inc = (score_q == '1) ? score_q : score_q + VAL_W'(1);
  assign opp_inc   = (opp_q   == '1) ? opp_q   : opp_q   + VAL_W'(1);

  // Factor judgement; divisor is forced nonzero so the modulo is always defined
  always_comb begin
    divisor   = (ANS < VAL_W'(2)) ? VAL_W'(1) : ANS;
    answer_ok = (ANS >= VAL_W'(2)) && (ANS <= target_q) &&
                ((target_q % divisor) == '0);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    time_d   = time_q;
    score_d  = score_q;
    opp_d    = opp_q;
    hit_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (START) state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (OK) begin
          state_d  = ST_ANSWER;
          target_d = NUM;
          time_d   = VAL_W'(TIME_LIMIT);
        end
      end

      ST_ANSWER: begin
        // Answers outrank the timeout tick in the same cycle
        if (ANS_VALID && answer_ok && OPP_HIT) begin
          state_d = ST_DRAW;
        end else if (ANS_VALID && answer_ok) begin
          state_d = ST_GOOD;
          score_d = score_inc;
          hit_d   = 1'b1;
        end else if (OPP_HIT) begin
          state_d = ST_OUCH;
          opp_d   = opp_inc;
        end else if (ANS_VALID) begin
          state_d = ST_LOCK;
        end else if (expiring) begin
          state_d = ST_DRAW;
          time_d  = '0;
        end else if (tick) begin
          time_d = time_q - VAL_W'(1);
        end
      end

      ST_LOCK: begin
        // Player is locked out; only the opponent or the clock can end the round
        if (OPP_HIT) begin
          state_d = ST_OUCH;
          opp_d   = opp_inc;
        end else if (expiring) begin
          state_d = ST_DRAW;
          time_d  = '0;
        end else if (tick) begin
          time_d = time_q - VAL_W'(1);
        end
      end

      ST_DRAW, ST_GOOD, ST_OUCH: begin
        if (disp_done) begin
          if (score_q == VAL_W'(WIN_SCORE))    state_d = ST_WIN;
          else if (opp_q == VAL_W'(WIN_SCORE)) state_d = ST_LOSE;
          else                                 state_d = ST_WAIT;
        end
      end

      ST_WIN, ST_LOSE: begin
        if (START) begin
          state_d  = ST_WAIT;
          score_d  = '0;
          opp_d    = '0;
          target_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Divider and display counter restart on every state entry
  always_comb begin
    cnt_d  = '0;
    disp_d = '0;
    if (state_d == state_q) begin
      cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
      disp_d = tick ? disp_q + VAL_W'(1) : disp_q;
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      time_q   <= '0;
      score_q  <= '0;
      opp_q    <= '0;
      hit_q    <= 1'b0;
      cnt_q    <= '0;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      time_q   <= time_d;
      score_q  <= score_d;
      opp_q    <= opp_d;
      hit_q    <= hit_d;
      cnt_q    <= cnt_d;
      disp_q   <= disp_d;
    end
  end

  assign STATE     = state_q;
  assign TARGET    = target_q;
  assign TIME_LEFT = time_q;
  assign SCORE     = score_q;
  assign OPP_SCORE = opp_q;
  assign HIT       = hit_q;

endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control with CLK_FREQ=10, TIME_LIMIT=3,
// DISP_SEC=1, WIN_SCORE=2. Expected outputs are queued when a step's
// stimulus is driven and popped once the DUT has clocked.
module tb_game_control;

  localparam logic [3:0] S_IDLE = 4'b0000;
  localparam logic [3:0] S_WAIT = 4'b0001;
  localparam logic [3:0] S_ANS  = 4'b0010;
  localparam logic [3:0] S_LOCK = 4'b0011;
  localparam logic [3:0] S_DRAW = 4'b0110;
  localparam logic [3:0] S_GOOD = 4'b1000;
  localparam logic [3:0] S_OUCH = 4'b1001;
  localparam logic [3:0] S_WIN  = 4'b1010;
  localparam logic [3:0] S_LOSE = 4'b1011;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       START, OK, ANS_VALID, OPP_HIT;
  logic [3:0] NUM, ANS;
  logic [3:0] STATE, TARGET, TIME_LEFT, SCORE, OPP_SCORE;
  logic       HIT;

  typedef struct {
    string      tag;
    logic [3:0] st, tg, tl, sc, op;
    logic       hit;
    bit         chk_tl;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  game_control #(
    .CLK_FREQ(10), .TIME_LIMIT(3), .DISP_SEC(1), .WIN_SCORE(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OK(OK), .NUM(NUM),
    .ANS_VALID(ANS_VALID), .ANS(ANS), .OPP_HIT(OPP_HIT),
    .STATE(STATE), .TARGET(TARGET), .TIME_LEFT(TIME_LEFT),
    .SCORE(SCORE), .OPP_SCORE(OPP_SCORE), .HIT(HIT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string tag, input string fld, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
  endtask

  task automatic push_exp(input string tag, input logic [3:0] st, input logic [3:0] tg,
                          input logic [3:0] tl, input logic [3:0] sc, input logic [3:0] op,
                          input logic hit, input bit chk_tl);
    exp_t e;
    e.tag = tag; e.st = st; e.tg = tg; e.tl = tl; e.sc = sc; e.op = op;
    e.hit = hit; e.chk_tl = chk_tl;
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    n_total++;
    assert (sb.size() > 0) n_pass++;
    else $error("FAIL scoreboard_empty observed=0 expected=1");
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp(e.tag, "state", STATE, e.st);
      cmp(e.tag, "target", TARGET, e.tg);
      if (e.chk_tl) cmp(e.tag, "time_left", TIME_LEFT, e.tl);
      cmp(e.tag, "score", SCORE, e.sc);
      cmp(e.tag, "opp_score", OPP_SCORE, e.op);
      cmp(e.tag, "hit", {3'b000, HIT}, {3'b000, e.hit});
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Queue expectation, advance n clocks, then compare
  task automatic step(input int n, input string tag, input logic [3:0] st, input logic [3:0] tg,
                      input logic [3:0] tl, input logic [3:0] sc, input logic [3:0] op,
                      input logic hit, input bit chk_tl = 1'b1);
    push_exp(tag, st, tg, tl, sc, op, hit, chk_tl);
    cyc(n);
    check_front();
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; OK = 1'b0; NUM = 4'd0;
    ANS_VALID = 1'b0; ANS = 4'd0; OPP_HIT = 1'b0;

    #12;
    push_exp("reset", S_IDLE, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    check_front();
    RST_N = 1'b1;
    step(1, "idle_after_reset", S_IDLE, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

    // Round 1: correct factor
    START = 1'b1;
    step(1, "t1_wait", S_WAIT, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    START = 1'b0;
    OK = 1'b1; NUM = 4'd6;
    step(1, "t1_answer", S_ANS, 4'd6, 4'd3, 4'd0, 4'd0, 1'b0);
    OK = 1'b0; NUM = 4'd0;
    step(4, "t1_hold", S_ANS, 4'd6, 4'd3, 4'd0, 4'd0, 1'b0);
    ANS_VALID = 1'b1; ANS = 4'd3;
    step(1, "t1_good", S_GOOD, 4'd6, 4'd3, 4'd1, 4'd0, 1'b1);
    ANS_VALID = 1'b0;
    step(1, "t1_hit_off", S_GOOD, 4'd6, 4'd3, 4'd1, 4'd0, 1'b0);
    step(8, "t1_disp", S_GOOD, 4'd6, 4'd3, 4'd1, 4'd0, 1'b0);
    step(1, "t1_back_wait", S_WAIT, 4'd6, 4'd3, 4'd1, 4'd0, 1'b0);

    // Round 2: wrong factor, lockout, timeout
    OK = 1'b1; NUM = 4'd7;
    step(1, "t2_answer", S_ANS, 4'd7, 4'd3, 4'd1, 4'd0, 1'b0);
    OK = 1'b0;
    ANS_VALID = 1'b1; ANS = 4'd4;
    step(1, "t2_lock", S_LOCK, 4'd7, 4'd3, 4'd1, 4'd0, 1'b0);
    ANS_VALID = 1'b0;
    step(9, "t2_tl3", S_LOCK, 4'd7, 4'd3, 4'd1, 4'd0, 1'b0);
    step(1, "t2_tl2", S_LOCK, 4'd7, 4'd2, 4'd1, 4'd0, 1'b0);
    step(10, "t2_tl1", S_LOCK, 4'd7, 4'd1, 4'd1, 4'd0, 1'b0);
    step(9, "t2_tl1_hold", S_LOCK, 4'd7, 4'd1, 4'd1, 4'd0, 1'b0);
    step(1, "t2_draw", S_DRAW, 4'd7, 4'd0, 4'd1, 4'd0, 1'b0);
    step(10, "t2_wait", S_WAIT, 4'd7, 4'd0, 4'd1, 4'd0, 1'b0);

    // Round 3: simultaneous correct answers draw; then opponent wins a round
    OK = 1'b1; NUM = 4'd8;
    step(1, "t3_answer", S_ANS, 4'd8, 4'd3, 4'd1, 4'd0, 1'b0);
    OK = 1'b0;
    ANS_VALID = 1'b1; ANS = 4'd2; OPP_HIT = 1'b1;
    step(1, "t3_draw", S_DRAW, 4'd8, 4'd3, 4'd1, 4'd0, 1'b0);
    ANS_VALID = 1'b0; OPP_HIT = 1'b0;
    step(10, "t3_wait", S_WAIT, 4'd8, 4'd3, 4'd1, 4'd0, 1'b0);
    OK = 1'b1; NUM = 4'd8;
    step(1, "t3b_answer", S_ANS, 4'd8, 4'd3, 4'd1, 4'd0, 1'b0);
    OK = 1'b0;
    OPP_HIT = 1'b1;
    step(1, "t3b_ouch", S_OUCH, 4'd8, 4'd3, 4'd1, 4'd1, 1'b0);
    OPP_HIT = 1'b0;
    step(10, "t3b_wait", S_WAIT, 4'd8, 4'd3, 4'd1, 4'd1, 1'b0);

    // Round 4: TARGET=1 has no valid factor; opponent hits on the expiring tick
    OK = 1'b1; NUM = 4'd1;
    step(1, "t4_answer", S_ANS, 4'd1, 4'd3, 4'd1, 4'd1, 1'b0);
    OK = 1'b0;
    ANS_VALID = 1'b1; ANS = 4'd1;
    step(1, "t4_lock", S_LOCK, 4'd1, 4'd3, 4'd1, 4'd1, 1'b0);
    ANS = 4'd2;
    step(1, "t4_lock_ignore", S_LOCK, 4'd1, 4'd3, 4'd1, 4'd1, 1'b0);
    ANS_VALID = 1'b0;
    step(28, "t4_tl1", S_LOCK, 4'd1, 4'd1, 4'd1, 4'd1, 1'b0);
    OPP_HIT = 1'b1;
    step(1, "t4_ouch_on_expiry", S_OUCH, 4'd1, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0);
    OPP_HIT = 1'b0;
    step(9, "t4_disp", S_OUCH, 4'd1, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0);
    step(1, "t4_lose", S_LOSE, 4'd1, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0);
    OK = 1'b1; NUM = 4'd5;
    step(1, "t4_ok_ignored", S_LOSE, 4'd1, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0);
    OK = 1'b0;
    START = 1'b1;
    step(1, "t4_restart", S_WAIT, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    START = 1'b0;

    // Match to WIN: ANS equal to TARGET is a valid factor
    OK = 1'b1; NUM = 4'd7;
    step(1, "t5_answer1", S_ANS, 4'd7, 4'd3, 4'd0, 4'd0, 1'b0);
    OK = 1'b0;
    ANS_VALID = 1'b1; ANS = 4'd7;
    step(1, "t5_good1", S_GOOD, 4'd7, 4'd3, 4'd1, 4'd0, 1'b1);
    ANS_VALID = 1'b0;
    step(10, "t5_wait1", S_WAIT, 4'd7, 4'd3, 4'd1, 4'd0, 1'b0);
    OK = 1'b1; NUM = 4'd9;
    step(1, "t5_answer2", S_ANS, 4'd9, 4'd3, 4'd1, 4'd0, 1'b0);
    OK = 1'b0;
    ANS_VALID = 1'b1; ANS = 4'd3;
    step(1, "t5_good2", S_GOOD, 4'd9, 4'd3, 4'd2, 4'd0, 1'b1);
    ANS_VALID = 1'b0;
    step(1, "t5_hit_off", S_GOOD, 4'd9, 4'd3, 4'd2, 4'd0, 1'b0);
    step(9, "t5_win", S_WIN, 4'd9, 4'd3, 4'd2, 4'd0, 1'b0);
    OK = 1'b1; NUM = 4'd4;
    step(2, "t5_ok_ignored", S_WIN, 4'd9, 4'd3, 4'd2, 4'd0, 1'b0);
    OK = 1'b0;
    START = 1'b1;
    step(1, "t5_restart", S_WAIT, 4'd0, 4'd3, 4'd0, 4'd0, 1'b0);
    START = 1'b0;

    // Mirror match to LOSE, second point taken while locked out
    OK = 1'b1; NUM = 4'd6;
    step(1, "t5m_answer1", S_ANS, 4'd6, 4'd3, 4'd0, 4'd0, 1'b0);
    OK = 1'b0;
    OPP_HIT = 1'b1;
    step(1, "t5m_ouch1", S_OUCH, 4'd6, 4'd3, 4'd0, 4'd1, 1'b0);
    OPP_HIT = 1'b0;
    step(10, "t5m_wait1", S_WAIT, 4'd6, 4'd3, 4'd0, 4'd1, 1'b0);
    OK = 1'b1; NUM = 4'd10;
    step(1, "t5m_answer2", S_ANS, 4'd10, 4'd3, 4'd0, 4'd1, 1'b0);
    OK = 1'b0;
    ANS_VALID = 1'b1; ANS = 4'd4;
    step(1, "t5m_lock", S_LOCK, 4'd10, 4'd3, 4'd0, 4'd1, 1'b0);
    ANS_VALID = 1'b0;
    OPP_HIT = 1'b1;
    step(1, "t5m_ouch2", S_OUCH, 4'd10, 4'd3, 4'd0, 4'd2, 1'b0);
    OPP_HIT = 1'b0;
    step(10, "t5m_lose", S_LOSE, 4'd10, 4'd3, 4'd0, 4'd2, 1'b0);

    // Asynchronous reset mid-ANSWER
    START = 1'b1;
    step(1, "t6_wait", S_WAIT, 4'd0, 4'd3, 4'd0, 4'd0, 1'b0);
    START = 1'b0;
    OK = 1'b1; NUM = 4'd6;
    step(1, "t6_answer", S_ANS, 4'd6, 4'd3, 4'd0, 4'd0, 1'b0);
    OK = 1'b0;
    #3;
    RST_N = 1'b0;
    push_exp("t6_async_reset", S_IDLE, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    #1;
    check_front();
    #2;
    RST_N = 1'b1;
    OK = 1'b1; NUM = 4'd5;
    step(1, "t6_ok_ignored", S_IDLE, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    OK = 1'b0;
    START = 1'b1;
    step(1, "t6_start", S_WAIT, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    START = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
